chip8_sprite_drawer: RTL and testbench

Sequencer that owns the Chip-8 framebuffer's read/write ports and executes the two display instructions: DXYN, which draws an N-row sprite with XOR and collision detection, and 00E0, which clears the screen. It sits between the CPU core, main memory and the framebuffer. The CPU pulses a start and waits for `done`. The block then runs a read-modify-write row loop: fetch the sprite byte from memory, fetch the framebuffer byte, XOR the two, and write the result back.

---
 rtl/chip8_sprite_drawer.sv | 177 +++++++++++++++++
 tb/tb_chip8_sprite_drawer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/chip8_sprite_drawer.sv
// Chip-8 DXYN / 00E0 sequencer.
// Each sprite row is a read-modify-write: fetch the sprite byte and the framebuffer
// byte, XOR them, then write the result back. Clear writes zero to every byte.
module chip8_sprite_drawer (
  input  logic        clk,
  input  logic        reset,
  input  logic        draw_start,
  input  logic [7:0]  draw_x,
  input  logic [7:0]  draw_y,
  input  logic [3:0]  draw_n,
  input  logic [11:0] draw_i,
  input  logic        clear_start,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_readdata,
  output logic [7:0]  fbvx_read,
  output logic [7:0]  fbvy_read,
  input  logic [7:0]  fb_readdata,
  output logic [7:0]  fbvx_write,
  output logic [7:0]  fbvy_write,
  output logic [7:0]  fbdata,
  output logic        fb_write
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  x0_q, x0_d, y0_q, y0_d;
  logic [3:0]  n_q, n_d;
  logic [11:0] i_q, i_d;
  logic [4:0]  r_q, r_d;
  logic [7:0]  clr_q, clr_d;
  logic        coll_q, coll_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [7:0]  fbvx_read_q, fbvx_read_d, fbvy_read_q, fbvy_read_d;
  logic [7:0]  fbvx_write_q, fbvx_write_d, fbvy_write_q, fbvy_write_d;

  logic [7:0]  mask;
  logic [4:0]  r_inc;
  logic [7:0]  y_nxt;
  logic [7:0]  clr_inc;

  // Sprite byte bit-reversed (MSB is leftmost pixel), clipped at the right edge.
  always_comb begin
    mask = '0;
    for (int k = 0; k < 8; k++)
      if (x0_q + 8'(k) <= 8'd63) mask[k] = mem_readdata[7-k];
  end

  // Next-state and operand/address sequencing.
  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    n_d          = n_q;
    i_d          = i_q;
    r_d          = r_q;
    clr_d        = clr_q;
    coll_d       = coll_q;
    mem_addr_d   = mem_addr_q;
    fbvx_read_d  = fbvx_read_q;
    fbvy_read_d  = fbvy_read_q;
    fbvx_write_d = fbvx_write_q;
    fbvy_write_d = fbvy_write_q;
    r_inc        = r_q + 5'd1;
    y_nxt        = y0_q + {3'b000, r_inc};
    clr_inc      = clr_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          state_d      = S_CLEAR;
          coll_d       = 1'b0;
          clr_d        = '0;
          fbvx_write_d = '0;
          fbvy_write_d = '0;
        end else if (draw_start) begin
          x0_d   = draw_x & 8'h3F;
          y0_d   = draw_y & 8'h1F;
          n_d    = draw_n;
          i_d    = draw_i;
          r_d    = '0;
          coll_d = 1'b0;
          if (draw_n == 4'd0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_FETCH;
            mem_addr_d  = draw_i;
            fbvx_read_d = draw_x & 8'h3F;
            fbvy_read_d = draw_y & 8'h1F;
          end
        end
      end
      S_FETCH: begin
        // Write address is set up here so it is stable for the whole WRITE cycle.
        state_d      = S_WRITE;
        fbvx_write_d = x0_q;
        fbvy_write_d = y0_q + {3'b000, r_q};
      end
      S_WRITE: begin
        coll_d = coll_q | (|(fb_readdata & mask));
        r_d    = r_inc;
        if (r_inc == {1'b0, n_q} || y_nxt > 8'd31) begin
          state_d = S_DONE;
        end else begin
          state_d     = S_FETCH;
          mem_addr_d  = i_q + {7'b0, r_inc};
          fbvy_read_d = y_nxt;
        end
      end
      S_CLEAR: begin
        if (clr_q == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          clr_d        = clr_inc;
          fbvx_write_d = {2'b00, clr_inc[2:0], 3'b000};
          fbvy_write_d = {3'b000, clr_inc[7:3]};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      n_q          <= '0;
      i_q          <= '0;
      r_q          <= '0;
      clr_q        <= '0;
      coll_q       <= 1'b0;
      mem_addr_q   <= '0;
      fbvx_read_q  <= '0;
      fbvy_read_q  <= '0;
      fbvx_write_q <= '0;
      fbvy_write_q <= '0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      n_q          <= n_d;
      i_q          <= i_d;
      r_q          <= r_d;
      clr_q        <= clr_d;
      coll_q       <= coll_d;
      mem_addr_q   <= mem_addr_d;
      fbvx_read_q  <= fbvx_read_d;
      fbvy_read_q  <= fbvy_read_d;
      fbvx_write_q <= fbvx_write_d;
      fbvy_write_q <= fbvy_write_d;
    end
  end

  // Outputs: strobes decode from state, write data is combinational from read data.
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    fb_write   = (state_q == S_WRITE) || (state_q == S_CLEAR);
    fbdata     = (state_q == S_WRITE) ? (fb_readdata ^ mask) : 8'h00;
    collision  = coll_q;
    mem_addr   = mem_addr_q;
    fbvx_read  = fbvx_read_q;
    fbvy_read  = fbvy_read_q;
    fbvx_write = fbvx_write_q;
    fbvy_write = fbvy_write_q;
  end

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Bench for chip8_sprite_drawer: memory/framebuffer environment plus a pixel-level
// reference model of DXYN and 00E0.
module tb_chip8_sprite_drawer;
  logic        clk = 1'b0, reset = 1'b1;
  logic        draw_start = 1'b0, clear_start = 1'b0;
  logic [7:0]  draw_x = '0, draw_y = '0;
  logic [3:0]  draw_n = '0;
  logic [11:0] draw_i = '0;
  logic        busy, done, collision, fb_write;
  logic [11:0] mem_addr;
  logic [7:0]  mem_readdata, fb_readdata;
  logic [7:0]  fbvx_read, fbvy_read, fbvx_write, fbvy_write, fbdata;

  chip8_sprite_drawer dut (
    .clk(clk), .reset(reset), .draw_start(draw_start), .draw_x(draw_x), .draw_y(draw_y),
    .draw_n(draw_n), .draw_i(draw_i), .clear_start(clear_start), .busy(busy), .done(done),
    .collision(collision), .mem_addr(mem_addr), .mem_readdata(mem_readdata),
    .fbvx_read(fbvx_read), .fbvy_read(fbvy_read), .fb_readdata(fb_readdata),
    .fbvx_write(fbvx_write), .fbvy_write(fbvy_write), .fbdata(fbdata), .fb_write(fb_write)
  );

  always #5 clk = ~clk;

  bit [7:0]    mem [4096];
  bit [71:0]   env_row [32];   // framebuffer; columns 64..71 are unreachable padding
  bit [71:0]   ref_row [32];
  logic        pre_en = 1'b0;
  logic [4:0]  pre_y = '0;
  logic [71:0] pre_val = '0;
  logic [23:0] wq[$], eq[$];
  int          n_chk = 0, n_err = 0;

  // Environment: one-cycle-latency memory and framebuffer, write capture.
  always @(posedge clk) begin
    mem_readdata <= mem[mem_addr];
    fb_readdata  <= (fbvx_read < 8'd64) ? env_row[fbvy_read[4:0]][fbvx_read[6:0] +: 8] : 8'h00;
    if (fb_write && fbvx_write < 8'd64 && fbvy_write < 8'd32) begin
      env_row[fbvy_write[4:0]][fbvx_write[6:0] +: 8] <= fbdata;
      wq.push_back({fbvx_write, fbvy_write, fbdata});
    end
    if (pre_en) env_row[pre_y] <= pre_val;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int y, input logic [71:0] val);
    pre_en = 1'b1; pre_y = 5'(y); pre_val = val; ref_row[y] = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Reference DXYN: XOR pixels MSB-first from the wrapped origin, clip right and bottom.
  task automatic ref_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                          input logic [11:0] i, output int ed, output bit ec);
    int x0, y0, k;
    bit [7:0] s;
    x0 = int'(x) % 64; y0 = int'(y) % 32; ec = 1'b0; k = 0;
    for (int r = 0; r < int'(n) && y0 + r < 32; r++) begin
      s = mem[12'(int'(i) + r)];
      for (int b = 0; b < 8; b++)
        if (x0 + b < 64 && s[7-b]) begin
          ec = ec | ref_row[y0+r][x0+b];
          ref_row[y0+r][x0+b] = ~ref_row[y0+r][x0+b];
        end
      eq.push_back({8'(x0), 8'(y0 + r), 8'(ref_row[y0+r] >> x0)});
      k++;
    end
    ed = 2 * k + 1;
  endtask

  task automatic ref_clear();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x += 8) begin
        ref_row[y][63:0] = '0;
        eq.push_back({8'(x), 8'(y), 8'h00});
      end
  endtask

  // Pulse a start, then count cycles until done (bounded). Cycle 1 follows the start edge.
  task automatic run_op(input bit clr, input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] n, input logic [11:0] i, input bit both,
                        input int inject, output int dcyc, output bit dcoll);
    wq.delete();
    draw_x = x; draw_y = y; draw_n = n; draw_i = i;
    clear_start = clr; draw_start = !clr || both;
    @(posedge clk); #1;
    clear_start = 1'b0; draw_start = 1'b0;
    dcyc = -1; dcoll = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (done) begin dcyc = c; dcoll = collision; break; end
      draw_start = (c == inject);
      @(posedge clk); #1;
    end
    draw_start = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_done", {63'b0, busy}, 64'd0);
  endtask

  task automatic check_op(input string tag, input int ed, input bit ec, input int dc, input bit dco);
    int bad;
    chk({tag, "_done_cycle"}, 64'(dc), 64'(ed));
    chk({tag, "_collision"}, {63'b0, dco}, {63'b0, ec});
    chk({tag, "_write_count"}, 64'(wq.size()), 64'(eq.size()));
    for (int j = 0; j < eq.size() && j < wq.size(); j++)
      chk({tag, "_write"}, {40'b0, wq[j]}, {40'b0, eq[j]});
    bad = 0;
    for (int y = 0; y < 32; y++) if (env_row[y] !== ref_row[y]) bad++;
    chk({tag, "_fb_rows_bad"}, 64'(bad), 64'd0);
  endtask

  task automatic do_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                         input logic [11:0] i);
    int ed, dc; bit ec, dco;
    eq.delete();
    ref_draw(x, y, n, i, ed, ec);
    run_op(1'b0, x, y, n, i, 1'b0, 0, dc, dco);
    check_op("draw", ed, ec, dc, dco);
  endtask

  task automatic do_clear(input bit both, input int inject);
    int dc; bit dco;
    eq.delete();
    ref_clear();
    run_op(1'b1, 8'd0, 8'd0, 4'd3, 12'd0, both, inject, dc, dco);
    check_op("clear", 257, 1'b0, dc, dco);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    for (int y = 0; y < 32; y++) preload(y, {8'($urandom), 32'($urandom), 32'($urandom)});
    @(posedge clk); #1;
    chk("reset_outputs", {8'b0, busy, done, collision, fb_write, mem_addr, fbvx_read, fbvy_read,
                          fbvx_write, fbvy_write, fbdata}, 64'd0);
    reset = 1'b0;

    // Clear with a coincident draw start and a draw start pulsed mid-clear.
    do_clear(1'b1, 100);

    // Digit "0" on a cleared screen, then the same draw again to erase it.
    mem[0] = 8'hF0; mem[1] = 8'h90; mem[2] = 8'h90; mem[3] = 8'h90; mem[4] = 8'hF0;
    do_draw(8'd0, 8'd0, 4'd5, 12'h000);
    do_draw(8'd0, 8'd0, 4'd5, 12'h000);

    // Right-edge clip over an existing AA byte.
    preload(3, (ref_row[3] & ~(72'hFF << 60)) | (72'hAA << 60));
    mem[12'h100] = 8'hFF;
    do_draw(8'd60, 8'd3, 4'd1, 12'h100);

    // Coordinate wrap plus bottom clip, address wrap, zero-row draw.
    do_draw(8'd66, 8'd30, 4'd5, 12'($urandom));
    do_draw(8'd200, 8'd10, 4'd15, 12'hFFA);
    do_draw(8'($urandom), 8'($urandom), 4'd0, 12'($urandom));

    for (int t = 0; t < 24; t++)
      do_draw(8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom));

    // Reset during the WRITE cycle of row 2 of an 8-row draw.
    wq.delete();
    draw_x = 8'd0; draw_y = 8'd0; draw_n = 4'd8; draw_i = 12'h200; draw_start = 1'b1;
    @(posedge clk); #1;
    draw_start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_pre_write", {63'b0, fb_write}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_outputs", {8'b0, busy, done, collision, fb_write, mem_addr, fbvx_read, fbvy_read,
                        fbvx_write, fbvy_write, fbdata}, 64'd0);
    chk("rst_write_count", 64'(wq.size()), 64'd3);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_idle", {62'b0, busy, fb_write}, 64'd0);

    do_clear(1'b0, 0);
    for (int t = 0; t < 3; t++)
      do_draw(8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
